// File: rtl/ks_serial_mul.sv
// ks_serial_mul: digit-serial carry-less (GF(2)[x]) multiplier.
// Consumes DIGIT bits of operand b per BUSY cycle, least significant digit first.
// Optional build macro KS_MOD_REDUCE_EN adds a one-cycle REDUCE state that
// reduces the product modulo POLY before it is presented on d.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high exactly in IDLE. out_valid is registered and rises the
// edge after the FSM enters DONE; d is stable while out_valid is high and is
// released by out_valid && out_ready.
module ks_serial_mul #(
    parameter int               WIDTH = 16,
    parameter int               DIGIT = 4,
    parameter logic [WIDTH:0]   POLY  = 17'h1002B
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-2:0]     d
);

    localparam int PW   = 2 * WIDTH - 1;
    localparam int NDIG = WIDTH / DIGIT;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

    // Elaboration-time sanity check of the configuration.
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0) || (POLY[WIDTH] != 1'b1)) begin : g_param_check
        $error("ks_serial_mul: bad WIDTH/DIGIT/POLY combination");
    end

`ifdef KS_MOD_REDUCE_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_REDUCE = 2'd2,
        S_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_DONE   = 2'd3
    } state_t;
`endif

    state_t           state;
    state_t           next_state;
    logic [PW-1:0]    a_sh;     // operand a, pre-shifted to the current digit position
    logic [WIDTH-1:0] b_sh;     // operand b, current digit in the low DIGIT bits
    logic [PW-1:0]    acc;
    logic [KW-1:0]    k;
    logic [PW-1:0]    pp;
    logic             last_digit;

    // Carry-less product of the shifted a with one DIGIT-wide slice of b.
    function automatic logic [PW-1:0] digit_mul(input logic [PW-1:0] x,
                                                input logic [DIGIT-1:0] dg);
        logic [PW-1:0] p;
        p = '0;
        for (int j = 0; j < DIGIT; j++) begin
            if (dg[j]) p = p ^ (x << j);
        end
        return p;
    endfunction

`ifdef KS_MOD_REDUCE_EN
    // Polynomial remainder of x modulo POLY, clearing bits from the top down.
    function automatic logic [WIDTH-1:0] poly_mod(input logic [PW-1:0] x);
        logic [PW-1:0] r;
        r = x;
        for (int i = PW - 1; i >= WIDTH; i--) begin
            if (r[i]) r = r ^ (PW'(POLY) << (i - WIDTH));
        end
        return r[WIDTH-1:0];
    endfunction
`endif

    assign pp         = digit_mul(a_sh, b_sh[DIGIT-1:0]);
    assign last_digit = (k == K_LAST);
    assign in_ready   = (state == S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (in_valid) next_state = S_BUSY;
`ifdef KS_MOD_REDUCE_EN
            S_BUSY:   if (last_digit) next_state = S_REDUCE;
            S_REDUCE: next_state = S_DONE;
`else
            S_BUSY:   if (last_digit) next_state = S_DONE;
`endif
            S_DONE:   if (out_valid && out_ready) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Datapath: operand capture, digit accumulation and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
            k    <= '0;
            d    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_sh <= PW'(a);
                        b_sh <= b;
                        acc  <= '0;
                        k    <= '0;
                    end
                end
                S_BUSY: begin
                    acc  <= acc ^ pp;
                    a_sh <= a_sh << DIGIT;
                    b_sh <= b_sh >> DIGIT;
                    k    <= last_digit ? '0 : k + 1'b1;
`ifndef KS_MOD_REDUCE_EN
                    if (last_digit) d <= acc ^ pp;
`endif
                end
`ifdef KS_MOD_REDUCE_EN
                S_REDUCE: d <= PW'(poly_mod(acc));
`endif
                default: ;
            endcase
        end
    end

    // Output valid: rises one edge after DONE is entered, drops on the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_valid <= 1'b0;
        else        out_valid <= (state == S_DONE) && !(out_valid && out_ready);
    end

endmodule
